// File: rtl/execute_pkg.sv
// Shared types for the execute_iter stage: ALU operation codes and FSM states.
package execute_pkg;

    localparam int unsigned ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_MUL   = 4'b1000,
        ALU_NOR   = 4'b1100
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } exec_state_t;

endpackage

// File: rtl/execute_iter_if.sv
// Handshake and datapath bundle between upstream issue, the execute stage and the E/M consumer.
interface execute_iter_if #(
    parameter int unsigned N = 64
);
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic         AluSrc;
    logic [3:0]   AluControl;
    logic [N-1:0] PC_E;
    logic [N-1:0] signImm_E;
    logic [N-1:0] readData1_E;
    logic [N-1:0] readData2_E;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] PCBranch_M;
    logic [N-1:0] aluResult_M;
    logic [N-1:0] writeData_M;
    logic         zero_M;
    logic         busy;

    modport master (
        output flush, in_valid, AluSrc, AluControl, PC_E, signImm_E,
               readData1_E, readData2_E, out_ready,
        input  in_ready, out_valid, PCBranch_M, aluResult_M, writeData_M,
               zero_M, busy
    );

    modport slave (
        input  flush, in_valid, AluSrc, AluControl, PC_E, signImm_E,
               readData1_E, readData2_E, out_ready,
        output in_ready, out_valid, PCBranch_M, aluResult_M, writeData_M,
               zero_M, busy
    );
endinterface

// File: rtl/iter_mul.sv
// Iterative shift-add multiplier: retires BITS_PER_CYCLE multiplier bits per cycle,
// done/product are valid combinationally during the final iteration.
module iter_mul #(
    parameter int unsigned N              = 64,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         kill,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] product
);

    localparam int unsigned S  = N / BITS_PER_CYCLE;
    localparam int unsigned CW = (S > 1) ? $clog2(S) : 1;

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_mcand;
    logic [N-1:0]  r_mplier;
    logic [N-1:0]  w_partial;

    // Accumulate the partial products of the current multiplier slice
    always_comb begin
        w_partial = r_acc;
        for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
            if (r_mplier[j]) begin
                w_partial = w_partial + (r_mcand << j);
            end
        end
    end

    assign done    = r_busy && (r_cnt == CW'(S - 1));
    assign product = w_partial;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (kill) begin
            r_busy <= 1'b0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
        end else if (r_busy) begin
            if (done) begin
                r_busy <= 1'b0;
            end else begin
                r_acc    <= w_partial;
                r_mcand  <= r_mcand << BITS_PER_CYCLE;
                r_mplier <= r_mplier >> BITS_PER_CYCLE;
                r_cnt    <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/execute_iter.sv
// LEGv8 execute stage with valid/ready handshakes, E/M output register and iterative MUL.
// Optional EXECUTE_PERF_EN adds saturating mul_count / stall_count ports.
module execute_iter
    import execute_pkg::*;
#(
    parameter int unsigned N              = 64,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    execute_iter_if.slave     bus
`ifdef EXECUTE_PERF_EN
    ,
    output logic [31:0]       mul_count,
    output logic [31:0]       stall_count
`endif
);

    exec_state_t  r_state;
    exec_state_t  w_next_state;
    logic         r_out_valid;
    logic         r_zero;
    logic [N-1:0] r_pcbranch;
    logic [N-1:0] r_alu_result;
    logic [N-1:0] r_write_data;
    logic [N-1:0] r_hold_pcbranch;
    logic [N-1:0] r_hold_write_data;

    logic         w_accept;
    logic         w_is_mul;
    logic         w_load_single;
    logic         w_load_mul;
    logic         w_mul_start;
    logic         w_mul_done;
    logic [N-1:0] w_op_b;
    logic [N-1:0] w_pcbranch;
    logic [N-1:0] w_alu;
    logic [N-1:0] w_product;

    assign bus.in_ready = (r_state == IDLE) && (!r_out_valid || bus.out_ready) && !bus.flush;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_is_mul     = (bus.AluControl == ALU_MUL);
    assign w_op_b       = bus.AluSrc ? bus.signImm_E : bus.readData2_E;
    assign w_pcbranch   = bus.PC_E + (bus.signImm_E << 2);

    always_comb begin
        w_alu = '0;
        case (bus.AluControl)
            ALU_AND:   w_alu = bus.readData1_E & w_op_b;
            ALU_ORR:   w_alu = bus.readData1_E | w_op_b;
            ALU_ADD:   w_alu = bus.readData1_E + w_op_b;
            ALU_SUB:   w_alu = bus.readData1_E - w_op_b;
            ALU_PASSB: w_alu = w_op_b;
            ALU_NOR:   w_alu = ~(bus.readData1_E | w_op_b);
            default:   w_alu = '0;
        endcase
    end

    iter_mul #(
        .N              (N),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_iter_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mul_start),
        .kill    (bus.flush),
        .a       (bus.readData1_E),
        .b       (w_op_b),
        .done    (w_mul_done),
        .product (w_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flush overrides everything: back to IDLE, no loads, no MUL start
    always_comb begin
        w_next_state  = r_state;
        w_load_single = 1'b0;
        w_load_mul    = 1'b0;
        w_mul_start   = 1'b0;
        if (bus.flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            w_mul_start  = 1'b1;
                            w_next_state = MUL;
                        end else begin
                            w_load_single = 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (w_mul_done) begin
                        w_load_mul   = 1'b1;
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid       <= 1'b0;
            r_zero            <= 1'b0;
            r_pcbranch        <= '0;
            r_alu_result      <= '0;
            r_write_data      <= '0;
            r_hold_pcbranch   <= '0;
            r_hold_write_data <= '0;
        end else begin
            if (bus.flush) begin
                r_out_valid <= 1'b0;
            end else if (w_load_single || w_load_mul) begin
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_load_single) begin
                r_pcbranch   <= w_pcbranch;
                r_alu_result <= w_alu;
                r_write_data <= bus.readData2_E;
                r_zero       <= (w_alu == '0);
            end else if (w_load_mul) begin
                r_pcbranch   <= r_hold_pcbranch;
                r_alu_result <= w_product;
                r_write_data <= r_hold_write_data;
                r_zero       <= (w_product == '0);
            end

            // Branch target and store data travel with the MUL while it iterates
            if (w_mul_start) begin
                r_hold_pcbranch   <= w_pcbranch;
                r_hold_write_data <= bus.readData2_E;
            end
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.PCBranch_M  = r_pcbranch;
    assign bus.aluResult_M = r_alu_result;
    assign bus.writeData_M = r_write_data;
    assign bus.zero_M      = r_zero;
    assign bus.busy        = (r_state == MUL);

`ifdef EXECUTE_PERF_EN
    logic [31:0] r_mul_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mul_count   <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_mul_start && (r_mul_count != '1)) begin
                r_mul_count <= r_mul_count + 32'd1;
            end
            if (bus.in_valid && !bus.in_ready && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign mul_count   = r_mul_count;
    assign stall_count = r_stall_count;
`endif

endmodule
